// File: rtl/bus_wait_pkg.sv
// bus_wait_pkg: shared types and constants for the bus wait-state responder.
// Contents:
//   region_t  - address region from the decoder (RAM is the default region)
//   state_t   - access FSM states
//   OPEN_BUS  - value returned on a timed-out external read
//   cnt_width - counter width that holds the largest wait/timeout value
package bus_wait_pkg;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_ROM,
        RGN_IO,
        RGN_EXT
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXT,
        ST_DONE
    } state_t;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bus_region_decode.sv
// bus_region_decode: combinational address-to-region decoder.
// Ports:
//   addr   in  16  CPU address
//   region out     decoded region, priority EXT > IO > ROM > RAM
module bus_region_decode
    import bus_wait_pkg::*;
#(
    parameter logic [15:0] IO_BASE  = 16'hD000,
    parameter logic [15:0] IO_MASK  = 16'hF000,
    parameter logic [15:0] ROM_BASE = 16'hE000,
    parameter logic [15:0] ROM_MASK = 16'hE000,
    parameter logic [15:0] EXT_BASE = 16'hC000,
    parameter logic [15:0] EXT_MASK = 16'hF000
) (
    input  logic [15:0] addr,
    output region_t     region
);

    always_comb begin
        region = ((addr & EXT_MASK) == EXT_BASE) ? RGN_EXT :
                 ((addr & IO_MASK)  == IO_BASE)  ? RGN_IO  :
                 ((addr & ROM_MASK) == ROM_BASE) ? RGN_ROM : RGN_RAM;
    end

endmodule

// File: rtl/bus_wait_ctrl.sv
// bus_wait_ctrl: 65xx memory-side responder that stretches slow accesses via
// ready and runs a timed req/ack handshake for the external region.
// Optional feature macro: WRITE_WAIT_EN (defined: writes stall like reads;
// undefined: writes never stall, external writes are posted).
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   valid, addr, rw, wdata   CPU access (rw=1 read)
//   ready           combinational access-complete strobe to the core
//   rdata           registered external read data
//   ext_req, ext_we, ext_addr, ext_wdata   registered external request
//   ext_ack, ext_rdata      external completion and read data
//   bus_err         one-cycle pulse on external timeout
module bus_wait_ctrl
    import bus_wait_pkg::*;
#(
    parameter logic [15:0] IO_BASE   = 16'hD000,
    parameter logic [15:0] IO_MASK   = 16'hF000,
    parameter int          IO_WAITS  = 2,
    parameter logic [15:0] ROM_BASE  = 16'hE000,
    parameter logic [15:0] ROM_MASK  = 16'hE000,
    parameter int          ROM_WAITS = 1,
    parameter logic [15:0] EXT_BASE  = 16'hC000,
    parameter logic [15:0] EXT_MASK  = 16'hF000,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic [7:0]  rdata,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        bus_err
);

    localparam int CW = cnt_width(IO_WAITS, ROM_WAITS, TIMEOUT);
    localparam logic [CW-1:0] IO_N  = CW'(IO_WAITS);
    localparam logic [CW-1:0] ROM_N = CW'(ROM_WAITS);
    localparam logic [CW-1:0] TO_N  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

`ifdef WRITE_WAIT_EN
    localparam bit POSTED = 1'b0;
`else
    localparam bit POSTED = 1'b1;
`endif

    region_t       region;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] tcnt;
    logic          pend;
    logic [CW-1:0] wn;
    logic          posted;
    logic          stretch;
    logic          idle_rdy;

    bus_region_decode #(
        .IO_BASE  (IO_BASE),
        .IO_MASK  (IO_MASK),
        .ROM_BASE (ROM_BASE),
        .ROM_MASK (ROM_MASK),
        .EXT_BASE (EXT_BASE),
        .EXT_MASK (EXT_MASK)
    ) u_decode (
        .addr   (addr),
        .region (region)
    );

    // posted: this access is an external write that completes immediately
    // while its handshake runs in the background. stretch: wait states apply.
    always_comb begin
        wn       = (region == RGN_IO) ? IO_N : (region == RGN_ROM) ? ROM_N : '0;
        posted   = POSTED && !rw;
        stretch  = !POSTED || rw;
        idle_rdy = !valid || ((region == RGN_EXT) ? (posted && !pend) : (!stretch || wn == '0));
        ready    = (state == ST_IDLE) ? idle_rdy :
                   (state == ST_WAIT) ? (cnt == '0) : (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            pend      <= 1'b0;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            rdata     <= OPEN_BUS;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            // Background handshake of a posted write; it can overlap IDLE
            // and WAIT, never EXT, because EXT cannot start while pending.
            if (pend) begin
                if (ext_ack) begin
                    ext_req <= 1'b0;
                    ext_we  <= 1'b0;
                    pend    <= 1'b0;
                end else if (tcnt == '0) begin
                    rdata   <= OPEN_BUS;
                    bus_err <= 1'b1;
                    ext_req <= 1'b0;
                    ext_we  <= 1'b0;
                    pend    <= 1'b0;
                end else begin
                    tcnt <= tcnt - ONE;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (valid && region == RGN_EXT && !pend) begin
                        ext_req   <= 1'b1;
                        ext_we    <= !rw;
                        ext_addr  <= addr;
                        ext_wdata <= wdata;
                        tcnt      <= TO_N;
                        if (posted)
                            pend <= 1'b1;
                        else
                            state <= ST_EXT;
                    end else if (valid && region != RGN_EXT && stretch && wn != '0) begin
                        cnt   <= wn - ONE;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - ONE;
                end
                ST_EXT: begin
                    // Ack is tested first so a same-cycle ack beats the timeout.
                    if (ext_ack) begin
                        if (!ext_we)
                            rdata <= ext_rdata;
                        ext_req <= 1'b0;
                        ext_we  <= 1'b0;
                        state   <= ST_DONE;
                    end else if (tcnt == '0) begin
                        rdata   <= OPEN_BUS;
                        bus_err <= 1'b1;
                        ext_req <= 1'b0;
                        ext_we  <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        tcnt <= tcnt - ONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// tb_bus_wait_ctrl: randomized self-checking bench for bus_wait_ctrl using a
// transaction-level latency model and a queued external device model.
module tb_bus_wait_ctrl;

    localparam int T = 15;
`ifdef WRITE_WAIT_EN
    localparam bit POSTED_M = 1'b0;
`else
    localparam bit POSTED_M = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] addr = 16'h0;
    logic        rw = 1'b1;
    logic [7:0]  wdata = 8'h0;
    logic        ready;
    logic [7:0]  rdata;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata = 8'h0;
    logic        bus_err;
    logic        dev_ack = 1'b0;
    logic        stray = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_until = 0;
    int exp_err = 0;
    int err_seen = 0;
    logic [7:0] last_rd = 8'hFF;

    int          dly_q[$];
    logic [7:0]  dat_q[$];
    logic [15:0] adr_q[$];
    logic        we_q[$];
    logic [7:0]  wd_q[$];

    assign ext_ack = dev_ack | stray;

    bus_wait_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .addr      (addr),
        .rw        (rw),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus_err === 1'b1) err_seen <= err_seen + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // External device: acks d cycles after ext_req rises (never if d >= T).
    initial begin : device
        int age;
        int cur_d;
        logic [7:0] cur_dat;
        logic [15:0] ea;
        logic ew;
        logic [7:0] ewd;
        logic prev;
        age = 0;
        cur_d = 1000;
        cur_dat = 8'h0;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ext_req === 1'b1 && !prev) begin
                age = 0;
                n_cmp++;
                if (dly_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL dev_request: ext_req rose with no access outstanding");
                    cur_d = 1000;
                end else begin
                    cur_d = dly_q.pop_front();
                    cur_dat = dat_q.pop_front();
                    ea = adr_q.pop_front();
                    ew = we_q.pop_front();
                    ewd = wd_q.pop_front();
                    if (ext_addr !== ea || ext_we !== ew || (ew && ext_wdata !== ewd)) begin
                        n_bad++;
                        $display("FAIL dev_request: got addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                                 ext_addr, ext_we, ext_wdata, ea, ew, ewd);
                    end
                end
            end else if (ext_req === 1'b1) begin
                age++;
            end
            prev = (ext_req === 1'b1);
            dev_ack = prev && age == cur_d && cur_d < T;
            ext_rdata = dev_ack ? cur_dat : 8'($urandom);
        end
    end

    function automatic int rgn_of(input logic [15:0] a);
        if ((a & 16'hF000) == 16'hC000) return 3;
        if ((a & 16'hF000) == 16'hD000) return 2;
        if ((a & 16'hE000) == 16'hE000) return 1;
        return 0;
    endfunction

    function automatic int waits_of(input int r);
        return (r == 2) ? 2 : (r == 1) ? 1 : 0;
    endfunction

    // One CPU access; d = device ack delay in cycles after ext_req rises.
    task automatic access(input logic [15:0] a, input logic r, input logic [7:0] wd,
                          input int d, input logic [7:0] dd, input string tag);
        int rg, p, s, dm, lat, n;
        bit ext, post;
        logic exp_be;
        rg = rgn_of(a);
        ext = (rg == 3);
        post = ext && POSTED_M && !r;
        p = cyc;
        dm = (d < T) ? d : T - 1;
        exp_be = (d >= T);
        s = (ext && busy_until > p) ? busy_until : p;
        if (!ext)
            lat = ((r || !POSTED_M) && waits_of(rg) > 0) ? waits_of(rg) + 1 : 1;
        else if (post) begin
            lat = s - p + 1;
            busy_until = s + 2 + dm;
        end else
            lat = s - p + dm + 3;
        if (ext) begin
            dly_q.push_back(d);
            dat_q.push_back(dd);
            adr_q.push_back(a);
            we_q.push_back(!r);
            wd_q.push_back(wd);
            if (d >= T) begin
                exp_err++;
                last_rd = 8'hFF;
            end else if (r)
                last_rd = dd;
        end
        valid = 1'b1;
        addr = a;
        rw = r;
        wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 200);
        n_cmp++;
        if (n != lat) begin
            n_bad++;
            $display("FAIL %s latency addr=%h rw=%0d: got %0d cycles, expected %0d", tag, a, r, n, lat);
        end
        if (ext && !post) begin
            n_cmp++;
            if (bus_err !== exp_be) begin
                n_bad++;
                $display("FAIL %s bus_err addr=%h: got %b, expected %b", tag, a, bus_err, exp_be);
            end
            if (r) begin
                n_cmp++;
                if (rdata !== last_rd) begin
                    n_bad++;
                    $display("FAIL %s rdata addr=%h: got %h, expected %h", tag, a, rdata, last_rd);
                end
            end
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (ext_req !== 1'b0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        idle(2);
        n_cmp++;
        if (ext_req !== 1'b0 || err_seen != exp_err) begin
            n_bad++;
            $display("FAIL %s drain: ext_req=%b bus_err pulses=%0d, expected ext_req=0 pulses=%0d",
                     tag, ext_req, err_seen, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({ready, ext_req, ext_we, bus_err, rdata, ext_addr, ext_wdata} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%b req=%b we=%b err=%b rdata=%h eaddr=%h ewd=%h, expected 1 0 0 0 ff 0000 00",
                     ready, ext_req, ext_we, bus_err, rdata, ext_addr, ext_wdata);
        end
        valid = 1'b1;
        addr = 16'hD010;
        rw = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_io_ready: got %b, expected 0", ready);
        end
        addr = 16'h0200;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ram_ready: got %b, expected 1", ready);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        reset = 1'b0;
        last_rd = 8'hFF;
        idle(1);
    endtask

    task automatic test_ram();
        access(16'h0200, 1'b1, 8'h00, 0, 8'h00, "ram_read");
        access(16'h4ABC, 1'b0, 8'h12, 0, 8'h00, "ram_write");
        access(16'hBFFF, 1'b1, 8'h00, 0, 8'h00, "ram_edge");
        access(16'h0200, 1'b1, 8'h00, 0, 8'h00, "ram_again");
    endtask

    task automatic test_io_rom();
        access(16'hD010, 1'b1, 8'h00, 0, 8'h00, "io_read");
        access(16'hDFFF, 1'b0, 8'h77, 0, 8'h00, "io_write");
        access(16'hE000, 1'b1, 8'h00, 0, 8'h00, "rom_read");
        access(16'hFFFC, 1'b1, 8'h00, 0, 8'h00, "rom_vector");
        access(16'hF123, 1'b0, 8'h33, 0, 8'h00, "rom_write");
        access(16'hD000, 1'b1, 8'h00, 0, 8'h00, "io_back_to_back");
    endtask

    task automatic test_ext_read();
        access(16'hC123, 1'b1, 8'h00, 3, 8'h5A, "ext_ack3");
        access(16'hC000, 1'b1, 8'h00, T, 8'h00, "ext_timeout");
        access(16'hCFFF, 1'b1, 8'h00, T - 1, 8'hA7, "ext_ack_at_limit");
        access(16'hC400, 1'b1, 8'h00, 0, 8'h11, "ext_ack0");
        drain("ext_read");
    endtask

    task automatic test_posted();
        access(16'hC000, 1'b0, 8'h96, 5, 8'h00, "posted_write");
        access(16'hC010, 1'b1, 8'h00, 2, 8'h3C, "read_after_write");
        access(16'hC020, 1'b0, 8'h01, T + 2, 8'h00, "write_timeout");
        access(16'hC030, 1'b0, 8'h02, 1, 8'h00, "write_after_write");
        access(16'hD020, 1'b1, 8'h00, 0, 8'h00, "io_during_pending");
        drain("posted");
    endtask

    task automatic test_stray_ack();
        @(posedge clk);
        #1;
        stray = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || ext_req !== 1'b0 || bus_err !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_ack_idle: got rdy=%b req=%b err=%b, expected 1 0 0", ready, ext_req, bus_err);
        end
        @(posedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdata !== last_rd || bus_err !== 1'b0 || ext_req !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_ack_after: got rdata=%h err=%b req=%b, expected rdata=%h err=0 req=0",
                     rdata, bus_err, ext_req, last_rd);
        end
        @(posedge clk);
        #1;
        access(16'hC044, 1'b1, 8'h00, 4, 8'hC3, "ext_after_stray");
        drain("stray");
    endtask

    task automatic test_reset_mid();
        int k;
        valid = 1'b1;
        addr = 16'hC050;
        rw = 1'b1;
        dly_q.push_back(200);
        dat_q.push_back(8'h00);
        adr_q.push_back(16'hC050);
        we_q.push_back(1'b0);
        wd_q.push_back(8'h00);
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_start: ready got %b, expected 0", ready);
        end
        for (k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (ext_req !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_req: ext_req got %b, expected 1", ext_req);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_rd = 8'hFF;
        @(negedge clk);
        n_cmp++;
        if (ext_req !== 1'b0 || bus_err !== 1'b0 || ready !== 1'b1 || rdata !== 8'hFF) begin
            n_bad++;
            $display("FAIL mid_reset_after: got req=%b err=%b rdy=%b rdata=%h, expected 0 0 1 ff",
                     ext_req, bus_err, ready, rdata);
        end
        @(posedge clk);
        #1;
        drain("mid_reset");
        access(16'hD010, 1'b1, 8'h00, 0, 8'h00, "io_after_reset");
    endtask

    task automatic test_random();
        logic [15:0] a;
        int d, sel;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(0, 16'hBFFF));
                1: a = 16'hE000 | 16'($urandom_range(0, 16'h1FFF));
                2: a = 16'hD000 | 16'($urandom_range(0, 16'h0FFF));
                default: a = 16'hC000 | 16'($urandom_range(0, 16'h0FFF));
            endcase
            sel = $urandom_range(0, 9);
            d = (sel < 7) ? $urandom_range(0, 4) : (sel == 7) ? T - 1 : (sel == 8) ? T : $urandom_range(6, 12);
            access(a, 1'($urandom_range(0, 1)), 8'($urandom), d, 8'($urandom), "random");
            idle($urandom_range(0, 2));
        end
        drain("random");
    endtask

    initial begin
        test_reset();
        test_ram();
        test_io_rom();
        test_ext_read();
        test_posted();
        test_stray_ack();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_wait_ctrl.md
# bus_wait_ctrl

Memory-side bus responder for the 65xx core. It decodes each CPU access into a speed region and drives the core's `ready` input low to stretch slow accesses by a fixed number of wait states. For the external region it runs a req/ack handshake with an off-chip device, with a timeout. It sits between the core's address/data bus and the memory/IO fabric, and it is the producer of the `ready` signal that gates T-state advance in the timing controller.

## Interface
- `IO_BASE`, 16'hD000: IO region match value.
- `IO_MASK`, 16'hF000: IO region address mask.
- `IO_WAITS`, 2: wait states for IO accesses (0 = zero-wait).
- `ROM_BASE`, 16'hE000: ROM region match value.
- `ROM_MASK`, 16'hE000: ROM region address mask.
- `ROM_WAITS`, 1: wait states for ROM accesses.
- `EXT_BASE`, 16'hC000: external handshake region match value.
- `EXT_MASK`, 16'hF000: external region address mask.
- `TIMEOUT`, 15: maximum cycles to wait for `ext_ack`, range 1..255.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  the CPU presents an access this cycle.
- `addr`  in  16  CPU address; held stable by the CPU while `ready`=0.
- `rw`  in  1  1 = read, 0 = write.
- `wdata`  in  8  CPU write data.
- `ready`  out  1  access completes this cycle; combinational from state and `addr` decode.
- `rdata`  out  8  registered read data returned for external reads.
- `ext_req`  out  1  external device request; registered.
- `ext_we`  out  1  external write strobe qualifier, valid while `ext_req`=1.
- `ext_addr`  out  16  latched external address.
- `ext_wdata`  out  8  latched external write data.
- `ext_ack`  in  1  external device done; `ext_rdata` is valid in the same cycle.
- `ext_rdata`  in  8  external read data.
- `bus_err`  out  1  one-cycle pulse when an external access times out.

## Operation
- Region decode, first match wins in priority order EXT > IO > ROM > RAM. A region matches when `(addr & MASK) == BASE`. RAM is the default and is always zero-wait.
- The FSM has 4 states: IDLE, WAIT, EXT, DONE.
- **IDLE**
  - `valid`=0: `ready`=1 and no action is taken.
  - Zero-wait region: `ready`=1 in the same cycle.
  - IO/ROM with N>0 wait states: `ready`=0, `cnt`<=N-1, next state WAIT.
  - EXT: `ready`=0, `ext_req`<=1, address and data are latched, `tcnt`<=TIMEOUT-1, next state EXT.
- **WAIT**
  - `ready`=0 while `cnt`!=0, and `cnt` decrements each cycle.
  - When `cnt`==0, `ready`=1 and the next state is IDLE.
  - Total access length is N+1 cycles.
- **EXT**
  - `ready`=0 throughout.
  - `ext_ack`=1: `rdata`<=`ext_rdata` (reads only), `ext_req`<=0, next state DONE.
  - `tcnt`==0 with no ack: `rdata`<=8'hFF, `bus_err` pulses for 1 cycle, `ext_req`<=0, next state DONE.
  - Ack and timeout in the same cycle: ack wins and `bus_err` stays 0.
- **DONE**: `ready`=1, next state IDLE.
- `ext_ack` seen while `ext_req`=0 is ignored.
- Counters are sized to `$clog2(max(IO_WAITS, ROM_WAITS, TIMEOUT)+1)` bits. `cnt` never wraps because the FSM leaves WAIT at 0.

## Timing
- Reset values: state IDLE, `ext_req`=0, `ext_we`=0, `bus_err`=0, `rdata`=8'hFF, `ext_addr`=0, `ext_wdata`=0, counters 0, posted-write flag cleared. While in reset with IDLE state, `ready` follows the IDLE rule.
- Reset mid-access: IDLE on the next edge and `ext_req` drops on that same edge. An in-flight external transfer is abandoned and no `bus_err` is raised.
- `ready` has no registered latency: zero-wait accesses complete in the cycle they are presented.
- EXT read latency: ack in cycle k means `ready`=1 in cycle k+1, with `rdata` already valid in that cycle.

## Configuration
- `WRITE_WAIT_EN` defined: writes are stretched exactly like reads (65C02 RDY semantics).
- `WRITE_WAIT_EN` undefined (NMOS semantics): writes never pull `ready` low.
  - IO/ROM writes complete in one cycle.
  - EXT writes are posted. `ext_req` is raised and a pending flag is set, but `ready` stays 1.
  - The handshake for a posted write runs in the background with the same timeout and error rules.
  - Any EXT access presented while a write is pending holds `ready`=0 until the pending write acks or times out, then proceeds normally.

## Structure
- Package `bus_wait_pkg` holds the region enum (RGN_RAM, RGN_ROM, RGN_IO, RGN_EXT), the FSM state enum, and the `8'hFF` open-bus constant.
- Sub-module `bus_region_decode` is purely combinational: `addr` to region, using the BASE/MASK parameters.

## Test plan
- RAM read at 16'h0200 with `valid`=1 -> `ready`=1 in the same cycle and the FSM stays IDLE.
- IO read at 16'hD010 with IO_WAITS=2 -> `ready` is 0,0,1 over three cycles, then IDLE.
- EXT read at 16'hC123, device acks 3 cycles after `ext_req` with 8'h5A -> `ready`=1 one cycle after ack and `rdata`=8'h5A.
- EXT read with no ack, TIMEOUT=15 -> `bus_err` pulses once after 15 EXT cycles, `rdata`=8'hFF, `ready`=1 the following cycle.
- Without WRITE_WAIT_EN: EXT write to 16'hC000 with `ready`=1 immediately, then an EXT read before ack -> the read stalls until the write acks and completes with the correct data. With the macro defined, the same write stalls until ack.
- `reset` asserted while in EXT mid-handshake -> next cycle `ext_req`=0, state IDLE, `bus_err`=0.
